// File: rtl/fod_pkg.sv
// Shared widths for the FOD controller/analog datapath interface and the
// lane-slice helper used to pick one lane out of a packed X4 bus.
package fod_pkg;
   localparam int N_LANE  = 4;
   localparam int MMD_W   = 7;
   localparam int DTC_W   = 10;
   localparam int SEG_BIN = 3;
   localparam int N_PH    = 1 << SEG_BIN;

   // Widest packed bus; narrower buses are zero-extended to this width.
   localparam int BUS_W   = N_LANE * DTC_W;

   // Bit b of lane k of a packed bus whose lanes are w bits wide.
   function automatic logic lane_bit(input logic [BUS_W-1:0] bus, input int w,
                                     input int k, input int b);
      return bus[k*w + b];
   endfunction
endpackage

// File: rtl/phase_therm_enc.sv
// Combinational 8-phase sampler encoder: reports the lowest 0->1 transition
// position; valid is low for all-zero and all-one words.
module phase_therm_enc
   import fod_pkg::*;
(
   input  logic [N_PH-1:0]    psamp,
   output logic [SEG_BIN-1:0] enc,
   output logic               valid
);

   // Scan from the top down so the lowest transition position wins.
   always_comb begin
      enc   = '0;
      valid = 1'b0;
      for (int i = N_PH-1; i >= 0; i--) begin
         if (psamp[i] && !psamp[(i + N_PH - 1) % N_PH]) begin
            enc   = SEG_BIN'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dcw_retimer.sv
// 4:1 divider-control-word serializer toward the MMD/retimer/DTC chain, with
// per-edge phase encoding packed four at a time back to the controller.
module dcw_retimer
   import fod_pkg::*;
(
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [N_LANE*MMD_W-1:0]   MMD_DCW_X4,
   input  logic [N_LANE-1:0]         RT_DCW_X4,
   input  logic [N_LANE*DTC_W-1:0]   DTC_DCW_X4,
   input  logic [N_PH-1:0]           PSAMP,
   output logic [MMD_W-1:0]          MMD_DCW,
   output logic                      RT_DCW,
   output logic [DTC_W-1:0]          DTC_DCW,
   output logic [N_LANE*SEG_BIN-1:0] PHE_X4,
   output logic                      LANE0
);

   logic [1:0]                    cnt_q, cnt_d;
   logic [N_LANE*MMD_W-1:0]       mmd_sh_q, mmd_sh_d;
   logic [N_LANE-1:0]             rt_sh_q, rt_sh_d;
   logic [N_LANE*DTC_W-1:0]       dtc_sh_q, dtc_sh_d;
   logic [MMD_W-1:0]              mmd_q, mmd_d;
   logic                          rt_q, rt_d;
   logic [DTC_W-1:0]              dtc_q, dtc_d;
   logic                          lane0_q, lane0_d;
   logic [2:0][SEG_BIN-1:0]       slot_q, slot_d;
   logic [N_LANE*SEG_BIN-1:0]     phe_q, phe_d;
   logic [SEG_BIN-1:0]            last_enc_q, last_enc_d;

   logic [SEG_BIN-1:0]            enc_raw, enc;
   logic                          enc_valid;
   logic                          load;
   logic [BUS_W-1:0]              mmd_bus, rt_bus, dtc_bus;

   phase_therm_enc u_enc (
      .psamp (PSAMP),
      .enc   (enc_raw),
      .valid (enc_valid)
   );

   assign load = (cnt_q == 2'd3);
   assign enc  = enc_valid ? enc_raw : last_enc_q;

   // On the load edge lane 0 comes straight from the inputs; otherwise the
   // next lane comes from the shadow. Either way the lane index is cnt+1.
   assign mmd_bus = BUS_W'(load ? MMD_DCW_X4 : mmd_sh_q);
   assign rt_bus  = BUS_W'(load ? RT_DCW_X4  : rt_sh_q);
   assign dtc_bus = BUS_W'(load ? DTC_DCW_X4 : dtc_sh_q);

   always_comb begin
      cnt_d      = cnt_q + 2'd1;
      mmd_sh_d   = mmd_sh_q;
      rt_sh_d    = rt_sh_q;
      dtc_sh_d   = dtc_sh_q;
      slot_d     = slot_q;
      phe_d      = phe_q;
      last_enc_d = enc;
      lane0_d    = load;
      mmd_d      = '0;
      dtc_d      = '0;
      rt_d       = lane_bit(rt_bus, 1, int'(cnt_d), 0);
      for (int b = 0; b < MMD_W; b++)
         mmd_d[b] = lane_bit(mmd_bus, MMD_W, int'(cnt_d), b);
      for (int b = 0; b < DTC_W; b++)
         dtc_d[b] = lane_bit(dtc_bus, DTC_W, int'(cnt_d), b);

      if (load) begin
         mmd_sh_d = MMD_DCW_X4;
         rt_sh_d  = RT_DCW_X4;
         dtc_sh_d = DTC_DCW_X4;
         phe_d    = {enc, slot_q[2], slot_q[1], slot_q[0]};
      end else begin
         slot_d[cnt_q] = enc;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q      <= 2'd3;
         mmd_sh_q   <= '0;
         rt_sh_q    <= '0;
         dtc_sh_q   <= '0;
         mmd_q      <= '0;
         rt_q       <= 1'b0;
         dtc_q      <= '0;
         lane0_q    <= 1'b0;
         slot_q     <= '0;
         phe_q      <= '0;
         last_enc_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         mmd_sh_q   <= mmd_sh_d;
         rt_sh_q    <= rt_sh_d;
         dtc_sh_q   <= dtc_sh_d;
         mmd_q      <= mmd_d;
         rt_q       <= rt_d;
         dtc_q      <= dtc_d;
         lane0_q    <= lane0_d;
         slot_q     <= slot_d;
         phe_q      <= phe_d;
         last_enc_q <= last_enc_d;
      end
   end

   assign MMD_DCW = mmd_q;
   assign RT_DCW  = rt_q;
   assign DTC_DCW = dtc_q;
   assign PHE_X4  = phe_q;
   assign LANE0   = lane0_q;

endmodule

// File: tb/tb_dcw_retimer.sv
// Scoreboard bench for dcw_retimer: stimulus queues hand-computed per-edge
// expectations, a negedge monitor pops and compares them.
module tb_dcw_retimer;

   logic        CLK;
   logic        RST;
   logic [27:0] MMD_DCW_X4;
   logic [3:0]  RT_DCW_X4;
   logic [39:0] DTC_DCW_X4;
   logic [7:0]  PSAMP;
   logic [6:0]  MMD_DCW;
   logic        RT_DCW;
   logic [9:0]  DTC_DCW;
   logic [11:0] PHE_X4;
   logic        LANE0;

   typedef struct {
      logic [6:0]  mmd;
      logic        rt;
      logic [9:0]  dtc;
      logic        lane0;
      logic [11:0] phe;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   dcw_retimer dut (
      .CLK        (CLK),
      .RST        (RST),
      .MMD_DCW_X4 (MMD_DCW_X4),
      .RT_DCW_X4  (RT_DCW_X4),
      .DTC_DCW_X4 (DTC_DCW_X4),
      .PSAMP      (PSAMP),
      .MMD_DCW    (MMD_DCW),
      .RT_DCW     (RT_DCW),
      .DTC_DCW    (DTC_DCW),
      .PHE_X4     (PHE_X4),
      .LANE0      (LANE0)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         total++;
         if (MMD_DCW !== e.mmd || RT_DCW !== e.rt || DTC_DCW !== e.dtc ||
             LANE0 !== e.lane0 || PHE_X4 !== e.phe) begin
            bad++;
            $display("FAIL edge%0d: got mmd=%0d rt=%0d dtc=%0d lane0=%0d phe=%o, want mmd=%0d rt=%0d dtc=%0d lane0=%0d phe=%o",
                     total, MMD_DCW, RT_DCW, DTC_DCW, LANE0, PHE_X4,
                     e.mmd, e.rt, e.dtc, e.lane0, e.phe);
         end
      end
   end

   task automatic ex(input logic [6:0] m, input logic r, input logic [9:0] d,
                     input logic l, input logic [11:0] p);
      exp_t e;
      e.mmd = m; e.rt = r; e.dtc = d; e.lane0 = l; e.phe = p;
      @(posedge CLK);
      q.push_back(e);
      #1;
   endtask

   task automatic set_a();
      MMD_DCW_X4 = {7'd11, 7'd10, 7'd9, 7'd8};
      RT_DCW_X4  = 4'b1010;
      DTC_DCW_X4 = {10'd3, 10'd2, 10'd1, 10'd0};
   endtask

   task automatic set_b();
      MMD_DCW_X4 = {7'd40, 7'd30, 7'd20, 7'd10};
      RT_DCW_X4  = 4'b0101;
      DTC_DCW_X4 = {10'd400, 10'd300, 10'd200, 10'd100};
   endtask

   initial begin
      RST   = 1'b1;
      PSAMP = 8'h00;
      set_a();

      repeat (3) ex(7'd0, 1'b0, 10'd0, 1'b0, 12'o0000);
      RST = 1'b0;

      // bundle A replayed twice
      repeat (2) begin
         ex(7'd8,  1'b0, 10'd0, 1'b1, 12'o0000);
         ex(7'd9,  1'b1, 10'd1, 1'b0, 12'o0000);
         ex(7'd10, 1'b0, 10'd2, 1'b0, 12'o0000);
         ex(7'd11, 1'b1, 10'd3, 1'b0, 12'o0000);
      end

      // inputs change mid-bundle: old bundle finishes, B appears after load
      ex(7'd8,  1'b0, 10'd0, 1'b1, 12'o0000);
      ex(7'd9,  1'b1, 10'd1, 1'b0, 12'o0000);
      set_b();
      ex(7'd10, 1'b0, 10'd2, 1'b0, 12'o0000);
      ex(7'd11, 1'b1, 10'd3, 1'b0, 12'o0000);
      ex(7'd10, 1'b1, 10'd100, 1'b1, 12'o0000);
      ex(7'd20, 1'b0, 10'd200, 1'b0, 12'o0000);
      ex(7'd30, 1'b1, 10'd300, 1'b0, 12'o0000);
      ex(7'd40, 1'b0, 10'd400, 1'b0, 12'o0000);
      ex(7'd10, 1'b1, 10'd100, 1'b1, 12'o0000);

      // packing enc 1,2,5,7
      PSAMP = 8'b0000_0010; ex(7'd20, 1'b0, 10'd200, 1'b0, 12'o0000);
      PSAMP = 8'b0000_0100; ex(7'd30, 1'b1, 10'd300, 1'b0, 12'o0000);
      PSAMP = 8'b0010_0000; ex(7'd40, 1'b0, 10'd400, 1'b0, 12'o0000);
      PSAMP = 8'b1000_0000; ex(7'd10, 1'b1, 10'd100, 1'b1, 12'o7521);

      // enc 4, 0, 3, then all-zero holds 3
      PSAMP = 8'b1111_0000; ex(7'd20, 1'b0, 10'd200, 1'b0, 12'o7521);
      PSAMP = 8'b0000_0111; ex(7'd30, 1'b1, 10'd300, 1'b0, 12'o7521);
      PSAMP = 8'b0011_1000; ex(7'd40, 1'b0, 10'd400, 1'b0, 12'o7521);
      PSAMP = 8'b0000_0000; ex(7'd10, 1'b1, 10'd100, 1'b1, 12'o3304);

      // all-one holds 3, wrap transition 7, lowest of several 2, all-zero holds 2
      PSAMP = 8'b1111_1111; ex(7'd20, 1'b0, 10'd200, 1'b0, 12'o3304);
      PSAMP = 8'b1000_0001; ex(7'd30, 1'b1, 10'd300, 1'b0, 12'o3304);
      PSAMP = 8'b0101_0100; ex(7'd40, 1'b0, 10'd400, 1'b0, 12'o3304);
      PSAMP = 8'b0000_0000; ex(7'd10, 1'b1, 10'd100, 1'b1, 12'o2273);

      // reset while lane 1 is driven (cnt==1 at the reset edge)
      ex(7'd20, 1'b0, 10'd200, 1'b0, 12'o2273);
      RST = 1'b1;
      set_a();
      ex(7'd0, 1'b0, 10'd0, 1'b0, 12'o0000);
      RST = 1'b0;
      ex(7'd8,  1'b0, 10'd0, 1'b1, 12'o0000);
      ex(7'd9,  1'b1, 10'd1, 1'b0, 12'o0000);
      ex(7'd10, 1'b0, 10'd2, 1'b0, 12'o0000);
      ex(7'd11, 1'b1, 10'd3, 1'b0, 12'o0000);

      @(negedge CLK);
      @(negedge CLK);
      #1;
      total++;
      if (q.size() != 0) begin
         bad++;
         $display("FAIL drain: pending=%0d want 0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time=%0t limit=100000", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/dcw_retimer.md
Name: dcw_retimer

Overview:
- Single-clock 4:1 serializer between the FOD digital controller and the analog datapath.
- Each controller update produces a bundle of four per-edge divider control words (MMD ratio, retimer polarity, DTC code). This block captures the bundle and replays one lane per CLK edge to the mmd/retimer/dtc chain.
- In the reverse direction it encodes the 8-phase sampler word once per edge and packs four phase-error codes into PHE_X4 for the controller.
- CLK is the DTC output clock, FDTC.

Parameters:
N_LANE, 4, lanes per bundle (fixed 4; counter is 2 bits)
MMD_W, 7, MMD divide-word width
DTC_W, 10, DTC code width
SEG_BIN, 3, phase-code width; sampler width is 2**SEG_BIN = 8

Ports:
CLK  in  1  FDTC clock, all logic on rising edge
RST  in  1  synchronous, active-high reset
MMD_DCW_X4  in  4*MMD_W  lane k at bits [k*MMD_W +: MMD_W]
RT_DCW_X4  in  4  lane k at bit k
DTC_DCW_X4  in  4*DTC_W  lane k at [k*DTC_W +: DTC_W]
PSAMP  in  8  phase-sampler word, already registered on CLK
MMD_DCW  out  MMD_W  current-lane MMD word, registered
RT_DCW  out  1  current-lane retimer polarity, registered
DTC_DCW  out  DTC_W  current-lane DTC code, registered
PHE_X4  out  4*SEG_BIN  four packed phase codes, lane k at [k*3 +: 3]
LANE0  out  1  high in the cycle lane 0 is on the outputs (bundle strobe for the controller)

Behaviour:
- Lane counter cnt, 2 bits.
  - Reset: cnt=3.
  - Every edge: cnt <= cnt+1 mod 4, so 3 wraps to 0.
- Edge with cnt==3 (bundle load):
  - Shadow registers <= the three X4 inputs.
  - Outputs <= lane 0 of the inputs, taken directly, not from the shadow.
- Edge with cnt==k, k<3:
  - Outputs <= shadow lane k+1.
  - Shadow unchanged.
  - Input changes during these cycles are ignored.
- Latency: a bundle present at the load edge appears on the outputs for the next 4 cycles, lanes 0,1,2,3 in order.
- LANE0 is registered and equals (cnt==0) after the edge, i.e. it is high while lane 0 is driven.
- Phase encoder (combinational, on PSAMP):
  - enc = lowest i in 0..7 with PSAMP[i]==1 and PSAMP[(i+7)%8]==0, i.e. the 0→1 transition.
  - All-0 or all-1 is invalid: enc = previous valid enc (register last_enc, reset 0).
  - Multiple transitions: the lowest i wins.
- Collection:
  - Edge with cnt==k, k<3: slot[k] <= enc.
  - Edge with cnt==3: PHE_X4 <= {enc, slot[2], slot[1], slot[0]}.
  - PHE_X4 holds between updates; it updates once per 4 cycles, coincident with the bundle load.
- Reset values: MMD_DCW=0, RT_DCW=0, DTC_DCW=0, shadows=0, slots=0, PHE_X4=0, LANE0=0, last_enc=0.
- RST asserted mid-bundle: everything returns to reset values on that edge. The first edge after RST deasserts is a load edge (cnt==3).
- No arithmetic saturation is needed; all paths are pure selection and registering.

Decomposition:
- Shared package fod_pkg: MMD_W, DTC_W, SEG_BIN, N_LANE, and the lane-slice helper function that extracts lane k from a packed X4 bus.
- One sub-module: phase_therm_enc. Combinational 8→3 transition encoder with a valid flag; the hold register stays in the parent.

Test Plan:
1. Reset: hold RST 3 cycles → all outputs 0 and LANE0=0. First edge after release loads the bundle and LANE0=1.
2. Serialization: MMD_DCW_X4 lanes = {11,10,9,8}, RT = 4'b1010, DTC lanes = {3,2,1,0}, held → outputs cycle MMD 8,9,10,11; RT 0,1,0,1; DTC 0,1,2,3. Repeats every 4 edges.
3. Bundle isolation: change the X4 inputs in the cycles where lanes 1–2 are driven → lanes 1–3 keep the old bundle; the new bundle appears only after the next load.
4. Encoder: PSAMP=8'b11110000 → enc 4; 8'b00000111 → enc 0; 8'b00000000 after 8'b00111000 → enc stays 3.
5. Packing: drive PSAMP giving enc 1,2,5,7 in lanes 0..3 → PHE_X4 = {3'd7,3'd5,3'd2,3'd1} = 12'o7521 after the lane-3 edge, held for 4 cycles.
6. Mid-bundle RST asserted with cnt==1 → outputs 0 next edge; after release, lane order restarts at lane 0 with the current inputs.
